// File: rtl/bcd_serial_adder_if.sv
// Handshake and data bundle for bcd_serial_adder.
// master (requester): drives start, a, b, carry_in; observes the status and result.
// slave  (adder):     samples the request; drives busy, done, sum, carry, invalid.
// Operands and sum are packed BCD, digit 0 in bits [3:0].
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  carry_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  carry;
  logic                  invalid;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry, invalid
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry, invalid
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder.
// Captures two packed DIGITS-digit BCD operands plus a carry-in on start (IDLE only),
// adds one decimal digit per clock LSD first, and presents the packed sum, decimal
// carry-out and an invalid-digit flag together with a one-cycle done pulse.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - bcd_serial_adder_if.slave (start/a/b/carry_in in; busy/done/sum/carry/invalid out)
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_serial_adder_if.slave    bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_reg_q, carry_reg_d;
  logic            inv_flag_q, inv_flag_d;
  logic            carry_q, carry_d;
  logic            invalid_q, invalid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [4:0]      raw;
  logic [3:0]      digit;
  logic            digit_c;
  logic            cap_invalid;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_reg_q <= 1'b0;
      inv_flag_q  <= 1'b0;
      carry_q     <= 1'b0;
      invalid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_reg_q <= carry_reg_d;
      inv_flag_q  <= inv_flag_d;
      carry_q     <= carry_d;
      invalid_q   <= invalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Single-digit decimal adder on the low nibbles. The +6 correction is done in
  // 4-bit arithmetic so only the low 4 bits of raw+6 survive, which also covers
  // non-BCD digits (raw up to 31).
  always_comb begin
    raw     = {1'b0, op_a_q[3:0]} + {1'b0, op_b_q[3:0]} + {4'b0000, carry_reg_q};
    digit   = raw[3:0];
    digit_c = 1'b0;
    if (raw > 5'd9) begin
      digit   = raw[3:0] + 4'd6;
      digit_c = 1'b1;
    end
  end

  // Flag any non-BCD digit in the operands presented at the capture edge.
  always_comb begin
    cap_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9)) begin
        cap_invalid = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = ADD;
      ADD:  if (idx_q == IW'(DIGITS - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture in IDLE, shift one digit per ADD cycle, publish in DONE.
  // The new digit enters at the top of the result so after DIGITS shifts digit 0
  // sits in bits [3:0].
  always_comb begin
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_d       = res_q;
    idx_d       = idx_q;
    carry_reg_d = carry_reg_q;
    inv_flag_d  = inv_flag_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    invalid_d   = invalid_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_a_d      = bus.a;
          op_b_d      = bus.b;
          carry_reg_d = bus.carry_in;
          idx_d       = '0;
          inv_flag_d  = cap_invalid;
        end
      end
      ADD: begin
        carry_reg_d = digit_c;
        res_d       = (res_q >> 4) | (W'(digit) << (W - 4));
        op_a_d      = op_a_q >> 4;
        op_b_d      = op_b_q >> 4;
        idx_d       = idx_q + IW'(1);
      end
      DONE: begin
        sum_d     = res_q;
        carry_d   = carry_reg_q;
        invalid_d = inv_flag_q;
      end
      default: ;
    endcase
  end

  // Registered status outputs; they trail the state by one cycle so done lines
  // up with the published result.
  always_comb begin
    busy_d = (state_q == ADD) || (state_q == DONE);
    done_d = (state_q == DONE);
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum     = sum_q;
  assign bus.carry   = carry_q;
  assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder with DIGITS=4 and DIGITS=1 instances.
// Expected results come from a decimal reference model (BCD -> integer, add,
// integer -> BCD) or from directed constants.
module tb_bcd_serial_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd_serial_adder_if #(.DIGITS(4)) bus4 ();
  bcd_serial_adder_if #(.DIGITS(1)) bus1 ();

  bcd_serial_adder #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  bcd_serial_adder #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guards against a run that never ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Decimal reference: convert packed BCD to integers, add, convert back.
  function automatic void dec_model(input int d, input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, output logic [15:0] s, output logic c);
    int unsigned av, bv, p, tot;
    av = 0; bv = 0; p = 1;
    for (int i = 0; i < d; i++) begin
      av += int'(a[4*i +: 4]) * p;
      bv += int'(b[4*i +: 4]) * p;
      p  *= 10;
    end
    tot = av + bv + int'(cin);
    c   = (tot >= p);
    tot = tot % p;
    s   = '0;
    for (int i = 0; i < d; i++) begin
      s[4*i +: 4] = 4'(tot % 10);
      tot = tot / 10;
    end
  endfunction

  function automatic logic [15:0] rand_bcd4();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // One transaction on the 4-digit instance, checking busy/done every cycle.
  task automatic tx4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                     input logic [15:0] es, input logic ec, input logic einv,
                     input bit inject, input bit tail, input string tag);
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.carry_in = cin; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.carry_in = 1'($urandom);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      bus4.start = inject && (k == 2);
      checks++;
      if (bus4.busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s busy cycle %0d: got %b want 1", tag, k, bus4.busy);
      end
      checks++;
      if (bus4.done !== (k == 5)) begin
        errors++;
        $display("[TB] FAIL %s done cycle %0d: got %b want %b", tag, k, bus4.done, (k == 5));
      end
    end
    checks++;
    if (bus4.sum !== es) begin
      errors++;
      $display("[TB] FAIL %s sum: got %h want %h", tag, bus4.sum, es);
    end
    checks++;
    if (bus4.carry !== ec) begin
      errors++;
      $display("[TB] FAIL %s carry: got %b want %b", tag, bus4.carry, ec);
    end
    checks++;
    if (bus4.invalid !== einv) begin
      errors++;
      $display("[TB] FAIL %s invalid: got %b want %b", tag, bus4.invalid, einv);
    end
    if (tail) begin
      @(posedge clk); #1;
      checks++;
      if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s after done: got done=%b busy=%b want 0 0", tag, bus4.done, bus4.busy);
      end
    end
  endtask

  // One transaction on the 1-digit instance.
  task automatic tx1(input logic [3:0] a, input logic [3:0] b, input logic cin,
                     input logic [3:0] es, input logic ec, input bit tail, input string tag);
    @(negedge clk);
    bus1.a = a; bus1.b = b; bus1.carry_in = cin; bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus1.a = 4'($urandom); bus1.b = 4'($urandom);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus1.busy !== 1'b1 || bus1.done !== (k == 2)) begin
        errors++;
        $display("[TB] FAIL %s status cycle %0d: got busy=%b done=%b want 1 %b",
                 tag, k, bus1.busy, bus1.done, (k == 2));
      end
    end
    checks++;
    if (bus1.sum !== es || bus1.carry !== ec || bus1.invalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s result: got sum=%h carry=%b inv=%b want %h %b 0",
               tag, bus1.sum, bus1.carry, bus1.invalid, es, ec);
    end
    if (tail) begin
      @(posedge clk); #1;
      checks++;
      if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s after done: got done=%b busy=%b want 0 0", tag, bus1.done, bus1.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.carry_in = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus4.busy, bus4.done, bus4.carry, bus4.invalid} !== 4'b0000 || bus4.sum !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset4: got busy=%b done=%b carry=%b inv=%b sum=%h want all 0",
               bus4.busy, bus4.done, bus4.carry, bus4.invalid, bus4.sum);
    end
    checks++;
    if ({bus1.busy, bus1.done, bus1.carry, bus1.invalid} !== 4'b0000 || bus1.sum !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset1: got busy=%b done=%b carry=%b inv=%b sum=%h want all 0",
               bus1.busy, bus1.done, bus1.carry, bus1.invalid, bus1.sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    tx4(16'h0456, 16'h0123, 1'b0, 16'h0579, 1'b0, 1'b0, 1'b0, 1'b1, "basic");
  endtask

  task automatic test_full_ripple();
    tx4(16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, "ripple");
  endtask

  task automatic test_back_to_back();
    tx4(16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_first");
    tx4(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_second");
  endtask

  // Digit 1 is 0xA: A+0=10 -> 0 with carry, so sum digits are 6, 0, 1, 0.
  task automatic test_invalid_and_ignored_start();
    tx4(16'h00A5, 16'h0001, 1'b0, 16'h0106, 1'b0, 1'b1, 1'b1, 1'b1, "invalid_inject");
  endtask

  task automatic test_reset_mid_add();
    bit seen_done;
    @(negedge clk);
    bus4.a = 16'h0456; bus4.b = 16'h0123; bus4.carry_in = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus4.busy, bus4.done, bus4.carry, bus4.invalid} !== 4'b0000 || bus4.sum !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL mid_reset: got busy=%b done=%b carry=%b inv=%b sum=%h want all 0",
               bus4.busy, bus4.done, bus4.carry, bus4.invalid, bus4.sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus4.done === 1'b1 || bus4.busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("[TB] FAIL mid_reset_quiet: got activity after abort want none");
    end
    tx4(16'h0456, 16'h0123, 1'b0, 16'h0579, 1'b0, 1'b0, 1'b0, 1'b1, "after_reset");
  endtask

  task automatic test_random_d4();
    logic [15:0] a, b, es;
    logic        cin, ec;
    for (int n = 0; n < 1000; n++) begin
      a   = rand_bcd4();
      b   = rand_bcd4();
      cin = 1'($urandom);
      dec_model(4, a, b, cin, es, ec);
      tx4(a, b, cin, es, ec, 1'b0, 1'b0, bit'($urandom_range(0, 1)), "rand4");
    end
  endtask

  task automatic test_random_d1();
    logic [15:0] a, b, es;
    logic        cin, ec;
    for (int n = 0; n < 1000; n++) begin
      a   = 16'($urandom_range(0, 9));
      b   = 16'($urandom_range(0, 9));
      cin = 1'($urandom);
      dec_model(1, a, b, cin, es, ec);
      tx1(a[3:0], b[3:0], cin, es[3:0], ec, bit'($urandom_range(0, 1)), "rand1");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_full_ripple();
    test_back_to_back();
    test_invalid_and_ignored_start();
    test_reset_mid_add();
    test_random_d4();
    test_random_d1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Digit-serial multi-digit BCD adder. It captures two packed DIGITS-digit BCD operands and a carry-in on a start handshake, then adds one decimal digit per clock, least-significant digit first, with a registered inter-digit carry. It presents the packed BCD sum and decimal carry-out with a one-cycle done pulse. It sits upstream of the BCD display/accumulate path and replaces a wide combinational ripple of single-digit decimal adders.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0]
- b  in  4*DIGITS  operand B, same packing
- carry_in  in  1  decimal carry into digit 0
- busy  out  1  high in ADD and DONE
- done  out  1  one-cycle pulse, result valid
- sum  out  4*DIGITS  packed BCD result, held until next done
- carry  out  1  decimal carry-out of most-significant digit, held with sum
- invalid  out  1  any captured digit of a or b > 9; held with sum

## Operation
- States: IDLE, ADD, DONE.
- IDLE → ADD when start=1:
  - latch a, b into operand shift registers;
  - latch carry_in into the carry register;
  - clear the digit index to 0;
  - compute the invalid flag from the captured operands (registered internally).
- ADD, each cycle:
  - raw = opA[3:0] + opB[3:0] + carry_reg (5-bit);
  - if raw > 9: digit = (raw + 6)[3:0], c = 1; else digit = raw[3:0], c = 0;
  - carry_reg ← c;
  - digit shifts into the top of the result shift register;
  - operands shift right 4 bits;
  - index increments.
- ADD → DONE after the cycle with index = DIGITS-1.
- DONE: sum ← result shift register; carry ← carry_reg; invalid ← captured flag; done = 1. Next state is IDLE unconditionally.
- start while busy (ADD or DONE) is ignored. Nothing is queued.
- Invalid digits do not stop the computation. The same formula is applied, so output digits may be non-BCD; invalid flags this.
- Operand inputs are don't-care except on the capture edge.

## Timing
- Capture edge = the rising edge where state=IDLE and start=1.
- busy rises 1 cycle after the capture edge.
- done is high exactly for cycle DIGITS+1 after the capture edge. sum/carry/invalid change on the same edge done rises.
- busy falls with done, so the next start is accepted in the cycle after done. Minimum issue interval is DIGITS+2 cycles.
- Reset values (asynchronous, any state):
  - state = IDLE;
  - busy = 0, done = 0;
  - sum = 0, carry = 0, invalid = 0;
  - internal registers cleared.
- Reset mid-operation aborts immediately. No done is produced; outputs read zero.
- DIGITS=1: exactly one ADD cycle; done at cycle 2.
- Max raw = 9+9+1 = 19 for valid BCD and 15+15+1 = 31 for invalid digits. Only the low 4 bits of raw+6 are kept.

## Test plan
- DIGITS=4, a=0x0456, b=0x0123, carry_in=0 → done at cycle 5; sum=0x0579, carry=0, invalid=0.
- a=0x1234, b=0x8766, carry_in=0 → sum=0x0000, carry=1 (full carry ripple across every digit).
- a=0x9999, b=0x0000, carry_in=1 → sum=0x0000, carry=1; then a=0x0000, b=0x0000, carry_in=0 issued the cycle after done → accepted, sum=0x0000, carry=0.
- a=0x00A5, b=0x0001 → invalid=1 with done. Also start pulsed during ADD → ignored, exactly one done, busy timing unchanged.
- rst_n asserted at cycle 2 of ADD → busy=0 immediately, sum=0, no done. Next start after release completes normally.
- Randomized valid BCD operands, 1000 transactions, DIGITS=1 and 4 → sum/carry match a decimal reference model. done occurs once per accepted start, at cycle DIGITS+1.
